// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared loader states and sizing constants.
// CHECK exists only when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DEPTH_DEF = 256;
  localparam int BYTES_PER_WORD = 4;
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RECV,
    WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_e;
endpackage

// File: rtl/prog_loader_word_assembler.sv
// word_assembler: packs four little-endian handshaken bytes into a 32-bit word.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        fire_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);
  logic [1:0]  cnt_q;
  logic [31:0] word_q;
  // The completing byte bypasses the register so the word is usable on the 4th transfer.
  assign word_valid_o = fire_i && cnt_q == 2'(BYTES_PER_WORD - 1);
  assign word_o = {byte_i, word_q[23:0]};
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i || word_valid_o) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (fire_i) begin
      cnt_q <= cnt_q + 2'd1;
      word_q[8*cnt_q +: 8] <= byte_i;
    end
  end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams bytes into program memory while holding the core in reset.
// Optional PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum word check.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [8:0]        word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              write_instruction,
  output logic [31:0]       ins,
  output logic [ADDR_W-1:0] addr,
  output logic              ins_mem_rst,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_e      state_q;
  logic [8:0]  wc_q, n_q;
  logic [31:0] word;
  logic        word_valid;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;
`endif
  word_assembler u_asm (
    .clk_i       (clk),
    .rst_ni      (rst),
    .clr_i       (state_q == CLEAR),
    .fire_i      (byte_valid && byte_ready),
    .byte_i      (byte_in),
    .word_o      (word),
    .word_valid_o(word_valid)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q           <= IDLE;
      wc_q              <= '0;
      n_q               <= '0;
      cpu_hold          <= 1'b1;
      addr              <= '0;
      ins               <= '0;
      byte_ready        <= 1'b0;
      write_instruction <= 1'b0;
      ins_mem_rst       <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q            <= '0;
`endif
    end else begin
      write_instruction <= 1'b0;
      ins_mem_rst       <= 1'b0;
      done              <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (word_count > 9'(DEPTH)) begin
            err     <= 1'b1;
            done    <= 1'b1;
            state_q <= DONE;
          end else begin
            wc_q        <= word_count;
            n_q         <= '0;
            addr        <= '0;
            err         <= 1'b0;
            cpu_hold    <= 1'b1;
            ins_mem_rst <= 1'b1;
            state_q     <= CLEAR;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
          end
        end
        CLEAR: begin
          state_q    <= wc_q == '0 ? DONE : RECV;
          done       <= wc_q == '0;
          byte_ready <= wc_q != '0;
        end
        RECV: if (word_valid) begin
          ins               <= word;
          write_instruction <= 1'b1;
          byte_ready        <= 1'b0;
          state_q           <= WRITE;
        end
        WRITE: begin
          n_q <= n_q + 9'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_q <= csum_q ^ ins;
`endif
          // addr only advances when another word follows, so it never passes DEPTH-1.
          if (n_q + 9'd1 < wc_q) begin
            addr       <= addr + ADDR_W'(1);
            byte_ready <= 1'b1;
            state_q    <= RECV;
          end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
            byte_ready <= 1'b1;
            state_q    <= CHECK;
`else
            done    <= 1'b1;
            state_q <= DONE;
`endif
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CHECK: if (word_valid) begin
          err        <= word != csum_q;
          byte_ready <= 1'b0;
          done       <= 1'b1;
          state_q    <= DONE;
        end
`endif
        DONE: begin
          cpu_hold <= err;
          busy     <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized loads checked against a word-list model of the loader.
module tb_prog_loader;
  localparam int DEPTH = 256;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, byte_valid = 1'b0;
  logic [8:0]  word_count = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_ready, write_instruction, ins_mem_rst, cpu_hold, busy, done, err;
  logic [31:0] ins;
  logic [9:0]  addr;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] pre[$];
  prog_loader dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .write_instruction(write_instruction), .ins(ins), .addr(addr),
    .ins_mem_rst(ins_mem_rst), .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_reset_state(input string tag);
    check({tag, "_outs"}, {cpu_hold, addr, ins, byte_ready, write_instruction, ins_mem_rst, busy, done, err},
          {1'b1, 10'd0, 32'd0, 6'd0});
  endtask
  task automatic load(input int n, input bit gaps, input int abort_cyc, input logic [31:0] csum_delta);
    logic [31:0] words[$];
    logic [7:0]  bq[$];
    logic [31:0] w, x;
    int          writes, clears, xfers, cyc, exp_lat;
    bit          got_done, ok, exp_err;
    x = 0; writes = 0; clears = 0; xfers = 0; cyc = 0; got_done = 0;
    ok = n <= DEPTH;
    if (ok) for (int i = 0; i < n; i++) begin
      w = pre.size() > 0 ? pre.pop_front() : $urandom;
      words.push_back(w);
      x ^= w;
      for (int b = 0; b < 4; b++) bq.push_back(w[8*b +: 8]);
    end
    if (CK && ok && n > 0) begin
      w = x ^ csum_delta;
      for (int b = 0; b < 4; b++) bq.push_back(w[8*b +: 8]);
    end
    exp_err = !ok || (CK && n > 0 && csum_delta != 0);
    exp_lat = 3 + 5 * n + ((CK && n > 0) ? 4 : 0);
    @(negedge clk);
    start = 1'b1;
    word_count = 9'(n);
    while (!got_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (write_instruction) begin
        check("write_addr", 64'(addr), 64'(writes));
        check("write_data", 64'(ins), writes < words.size() ? 64'(words[writes]) : 64'hx);
        writes++;
      end
      clears += int'(ins_mem_rst);
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (cyc == abort_cyc) begin
        rst = 1'b0;
        byte_valid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_reset_state("abort");
        rst = 1'b1;
        writes = 0;
        for (int i = 0; i < 12; i++) begin
          byte_valid = 1'b1;
          byte_in = 8'($urandom);
          @(negedge clk);
          writes += int'(write_instruction) + int'(busy);
        end
        byte_valid = 1'b0;
        check("abort_quiet", 64'(writes), 64'd0);
        return;
      end
      start = $urandom_range(0, 3) == 0;
      word_count = 9'($urandom_range(0, 300));
      byte_valid = bq.size() > 0 && (!gaps || cyc % 2 == 0);
      byte_in = bq.size() > 0 ? bq[0] : 8'($urandom);
      if (byte_valid && byte_ready) begin
        void'(bq.pop_front());
        xfers++;
      end
    end
    start = 1'b0;
    byte_valid = 1'b0;
    check("done_seen", 64'(got_done), 64'd1);
    check("done_busy_err", {busy, err}, {1'b1, exp_err});
    if (!gaps && ok) check("latency", 64'(cyc + 1), 64'(exp_lat));
    check("writes", 64'(writes), ok ? 64'(n) : 64'd0);
    check("clears", 64'(clears), ok ? 64'd1 : 64'd0);
    check("xfers", 64'(xfers), ok ? 64'(4 * n + ((CK && n > 0) ? 4 : 0)) : 64'd0);
    @(negedge clk);
    check("after_done", {done, busy, cpu_hold, err}, {2'b00, exp_err, exp_err});
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b1;
    @(negedge clk);
    pre = '{32'h0000_0013, 32'h0010_0093};
    load(2, 1'b0, 0, 0);
    load(0, 1'b0, 0, 0);
    load(300, 1'b0, 0, 0);
    load(1, 1'b1, 0, 0);
    for (int i = 0; i < 6; i++) load($urandom_range(1, 6), 1'($urandom), 0, 0);
    load(3, 1'b0, 8, 0);
    load(2, 1'b0, 0, 0);
    load(DEPTH, 1'b0, 0, 0);
    load(DEPTH + 1, 1'b0, 0, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    pre = '{32'h1111_1111, 32'h2222_2222};
    load(2, 1'b0, 0, 0);
    pre = '{32'h1111_1111, 32'h2222_2222};
    load(2, 1'b0, 0, 32'h3);
    load(3, 1'b1, 0, 32'h0100_0000);
    load(3, 1'b1, 0, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: ADDR_W, 10, program-memory address width.
REQ-002 Parameter: DEPTH, 256, number of loadable instruction words.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  load request; sampled only in IDLE.
REQ-006 word_count  in  9  number of instruction words to load (0..DEPTH); sampled with start.
REQ-007 byte_in  in  8  instruction byte stream, little-endian within each word.
REQ-008 byte_valid  in  1  byte_in valid.
REQ-009 byte_ready  out  1  loader accepts byte_in; a transfer occurs when byte_valid and byte_ready are both high.
REQ-010 write_instruction  out  1  program-memory write strobe.
REQ-011 ins  out  32  assembled instruction word.
REQ-012 addr  out  ADDR_W  program-memory write address.
REQ-013 ins_mem_rst  out  1  program-memory clear strobe.
REQ-014 cpu_hold  out  1  holds the core in reset while high.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse at load completion.
REQ-017 err  out  1  sticky load-error flag.

Function
REQ-018 States SHALL be IDLE, CLEAR, RECV, WRITE, CHECK (only when CHECKSUM_EN is defined), and DONE.
REQ-019 IDLE with start=1 and word_count<=DEPTH SHALL do the following: latch word_count, clear err, set cpu_hold=1, and go to CLEAR.
REQ-020 IDLE with start=1 and word_count>DEPTH SHALL set err=1 and go to DONE without any memory access.
REQ-021 CLEAR SHALL assert ins_mem_rst for exactly one cycle, then go to DONE if the latched count is 0, else to RECV.
REQ-022 RECV SHALL hold byte_ready=1 and shift in one byte per transfer; the first byte goes to ins[7:0].
REQ-023 The 4th transfer SHALL cause the next state to be WRITE.
REQ-024 Gaps in byte_valid SHALL stall RECV without losing bytes.
REQ-025 WRITE SHALL last one cycle, with write_instruction=1, byte_ready=0, and ins/addr stable.
REQ-026 After WRITE, addr SHALL increment by 1 and the written-word count SHALL increment by 1.
REQ-027 After WRITE, the next state SHALL be RECV if words remain, else CHECK (when CHECKSUM_EN is defined) or DONE.
REQ-028 addr SHALL start at 0 for each load and SHALL never exceed DEPTH-1; no wrap-around can occur.
REQ-029 DONE SHALL last one cycle, pulse done=1, clear cpu_hold, and return to IDLE.
REQ-030 Load latency SHALL be 3 + 5*N cycles from start to done for N words with back-to-back bytes, without the checksum.
REQ-031 start while busy SHALL be ignored.
REQ-032 byte_valid outside RECV/CHECK SHALL be ignored because byte_ready=0.

Reset
REQ-033 When rst=0 at a clock edge, the block SHALL go to IDLE with: cpu_hold=1; addr=0; ins=0; counters=0; and byte_ready, write_instruction, ins_mem_rst, busy, done, and err all 0.
REQ-034 Reset mid-load SHALL abort immediately with no further write strobes; memory contents are then undefined and cpu_hold stays 1 until a successful DONE.

Configuration
REQ-035 Macro PROG_LOADER_CHECKSUM_EN: when defined, the block SHALL keep a running 32-bit XOR of all written words, cleared on start.
REQ-036 When PROG_LOADER_CHECKSUM_EN is defined, CHECK SHALL accept 4 more bytes as a checksum word with no write, then go to DONE.
REQ-037 When PROG_LOADER_CHECKSUM_EN is defined, a checksum mismatch SHALL set err=1, and cpu_hold SHALL remain 1 after DONE.
REQ-038 When PROG_LOADER_CHECKSUM_EN is undefined, the block SHALL have no CHECK state and err SHALL be set only by REQ-020.

Structure
REQ-039 The state enum, the default ADDR_W/DEPTH values, and the byte-per-word constant (4) SHALL live in the shared CPU package.
REQ-040 Byte assembly SHALL be one sub-module, word_assembler: byte handshake in, 32-bit word plus word_valid out, with a clear input.
REQ-041 The FSM, counters, and checksum SHALL remain in prog_loader.

Verification
REQ-042 Reset, then start with word_count=2 and bytes 13 00 00 00 93 00 10 00 back-to-back -> ins_mem_rst pulse once, writes 0x00000013@0 and 0x00100093@1, done at cycle 13, cpu_hold=0.
REQ-043 word_count=0 -> CLEAR then DONE, no write_instruction, done 3 cycles after start.
REQ-044 word_count=300 -> err=1, no ins_mem_rst, no writes, done pulses, cpu_hold stays 1.
REQ-045 word_count=1 with byte_valid toggling every other cycle -> exactly 4 transfers, single write of the correct word, no byte dropped or duplicated.
REQ-046 rst=0 asserted during the 2nd word of a 3-word load -> next cycle IDLE, all outputs at reset values, no further write strobes.
REQ-047 With PROG_LOADER_CHECKSUM_EN, words 0x11111111 and 0x22222222 plus checksum 0x33333333 -> err=0 and cpu_hold=0; checksum 0x33333330 -> err=1 and cpu_hold=1.
